// File: rtl/sand_frame_sequencer_if.sv
// Brush request handshake and cell-buffer write bus
// shared by the brush source and the frame sequencer.
interface sand_frame_sequencer_if #(
  parameter int ADDR_WIDTH = 19,
  parameter int DATA_WIDTH = 2
);
  logic                  brush_valid_i;
  logic                  brush_ready_o;
  logic [ADDR_WIDTH-1:0] brush_addr_i;
  logic [DATA_WIDTH-1:0] brush_data_i;
  logic [ADDR_WIDTH-1:0] wr_address_o;
  logic [DATA_WIDTH-1:0] wr_data_o;
  logic                  wr_en_o;
  logic                  wr_both_o;

  modport master (
    output brush_valid_i, brush_addr_i, brush_data_i,
    input  brush_ready_o, wr_address_o, wr_data_o,
    input  wr_en_o, wr_both_o
  );

  modport slave (
    input  brush_valid_i, brush_addr_i, brush_data_i,
    output brush_ready_o, wr_address_o, wr_data_o,
    output wr_en_o, wr_both_o
  );
endinterface

// File: rtl/sand_frame_sequencer.sv
// Per-frame run/brush/swap/clear controller for the sand engine.
// Optional SAND_FRAME_STATS_EN adds frame and run-length counters.
module sand_frame_sequencer #(
  parameter int ACTIVE_COLUMNS = 640,
  parameter int ACTIVE_ROWS    = 480,
  parameter int ADDR_WIDTH     = $clog2(ACTIVE_COLUMNS*ACTIVE_ROWS),
  parameter int DATA_WIDTH     = 2,
  parameter int FRAME_DIV      = 1,
  parameter int BRUSH_MAX      = 64,
  parameter int TIMEOUT_CYCLES = 1048576
) (
  input  logic clk_i,
  input  logic reset_ni,
  input  logic frame_tick_i,
  output logic engine_ready_o,
  input  logic engine_done_i,
  input  logic clear_i,
  sand_frame_sequencer_if.slave bus,
  output logic buf_sel_o,
  output logic busy_o,
  output logic overrun_o,
  output logic timeout_o
`ifdef SAND_FRAME_STATS_EN
  ,
  output logic [15:0] frames_run_o,
  output logic [31:0] last_run_cycles_o
`endif
);

  localparam int CELLS = ACTIVE_COLUMNS * ACTIVE_ROWS;
  localparam int DIV_W = (FRAME_DIV > 1) ? $clog2(FRAME_DIV) : 1;
  localparam int BR_W  = $clog2(BRUSH_MAX + 1);
  localparam int TO_W  = $clog2(TIMEOUT_CYCLES + 1);

  // one extra bit so out-of-grid addresses compare correctly
  localparam logic [ADDR_WIDTH:0] CELLS_W =
    CELLS[ADDR_WIDTH:0];
  localparam logic [ADDR_WIDTH-1:0] CELL_LAST =
    ADDR_WIDTH'(CELLS - 1);
  localparam logic [DIV_W-1:0] DIV_LAST =
    DIV_W'(FRAME_DIV - 1);
  localparam logic [BR_W-1:0] BR_LAST =
    BR_W'(BRUSH_MAX - 1);
  localparam logic [TO_W-1:0] TO_LAST =
    TO_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE, RUN, BRUSH, SWAP, CLEAR
  } state_t;

  state_t state, state_nxt;

  logic [DIV_W-1:0]      div;
  logic [BR_W-1:0]       brush_cnt;
  logic [TO_W-1:0]       run_cnt;
  logic [ADDR_WIDTH-1:0] sweep;
  logic                  clear_pend;

  logic                  accept;
  logic                  run_exit;
  logic                  time_hit;
  logic                  div_step;
  logic                  clear_go;
  logic                  in_grid;
  logic [ADDR_WIDTH-1:0] waddr;
  logic [DATA_WIDTH-1:0] wdata;
  logic                  wen;
  logic                  wboth;
  logic                  bready;

  assign in_grid = {1'b0, bus.brush_addr_i} < CELLS_W;

  assign bus.wr_address_o  = waddr;
  assign bus.wr_data_o     = wdata;
  assign bus.wr_en_o       = wen;
  assign bus.wr_both_o     = wboth;
  assign bus.brush_ready_o = bready;
  assign busy_o            = (state != IDLE);

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) state <= IDLE;
    else           state <= state_nxt;
  end

  always_comb begin
    state_nxt      = state;
    engine_ready_o = 1'b0;
    bready         = 1'b0;
    wen            = 1'b0;
    wboth          = 1'b0;
    waddr          = '0;
    wdata          = '0;
    accept         = 1'b0;
    run_exit       = 1'b0;
    time_hit       = 1'b0;
    div_step       = 1'b0;
    clear_go       = 1'b0;
    unique case (state)
      IDLE: begin
        if (frame_tick_i) begin
          if (clear_pend || clear_i) begin
            clear_go  = 1'b1;
            state_nxt = CLEAR;
          end else if (div == DIV_LAST) begin
            engine_ready_o = 1'b1;
            state_nxt      = RUN;
          end else begin
            div_step = 1'b1;
          end
        end
      end
      RUN: begin
        if (engine_done_i) begin
          run_exit  = 1'b1;
          state_nxt = BRUSH;
        end else if (run_cnt == TO_LAST) begin
          run_exit  = 1'b1;
          time_hit  = 1'b1;
          state_nxt = BRUSH;
        end
      end
      BRUSH: begin
        bready = 1'b1;
        if (bus.brush_valid_i) begin
          accept = 1'b1;
          if (in_grid) begin
            wen   = 1'b1;
            waddr = bus.brush_addr_i;
            wdata = bus.brush_data_i;
          end
          if (brush_cnt == BR_LAST) state_nxt = SWAP;
        end else begin
          state_nxt = SWAP;
        end
      end
      SWAP: state_nxt = IDLE;
      CLEAR: begin
        wen   = 1'b1;
        wboth = 1'b1;
        waddr = sweep;
        if (sweep == CELL_LAST) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      div        <= '0;
      brush_cnt  <= '0;
      run_cnt    <= '0;
      sweep      <= '0;
      clear_pend <= 1'b0;
      buf_sel_o  <= 1'b0;
      overrun_o  <= 1'b0;
      timeout_o  <= 1'b0;
    end else begin
      if (engine_ready_o)  div <= '0;
      else if (div_step)   div <= div + DIV_W'(1);
      if (run_exit)           run_cnt <= '0;
      else if (state == RUN)  run_cnt <= run_cnt + TO_W'(1);
      if (state == SWAP)  brush_cnt <= '0;
      else if (accept)    brush_cnt <= brush_cnt + BR_W'(1);
      if (state == CLEAR)
        sweep <= (sweep == CELL_LAST) ? '0
                 : sweep + ADDR_WIDTH'(1);
      // consume the request on entry; a new one during the sweep re-arms it
      if (clear_go)     clear_pend <= 1'b0;
      else if (clear_i) clear_pend <= 1'b1;
      if (state == SWAP) buf_sel_o <= ~buf_sel_o;
      if (frame_tick_i && state != IDLE) overrun_o <= 1'b1;
      if (time_hit) timeout_o <= 1'b1;
    end
  end

`ifdef SAND_FRAME_STATS_EN
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      frames_run_o      <= '0;
      last_run_cycles_o <= '0;
    end else begin
      if (engine_ready_o) frames_run_o <= frames_run_o + 16'd1;
      if (run_exit)
        last_run_cycles_o <= 32'(run_cnt) + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_sand_frame_sequencer.sv
// Directed plus randomized frame-sequence checks for
// sand_frame_sequencer against a frame-level model.
module tb_sand_frame_sequencer;

  localparam int COLS  = 8;
  localparam int ROWS  = 4;
  localparam int CELLS = COLS * ROWS;
  localparam int AW    = 6;
  localparam int FDIV  = 2;
  localparam int BMAX  = 3;
  localparam int TMO   = 16;

  logic clk = 1'b0;
  logic reset_ni = 1'b0;
  logic frame_tick = 1'b0;
  logic engine_ready;
  logic engine_done = 1'b0;
  logic clear = 1'b0;
  logic buf_sel, busy, overrun, timeout;

  sand_frame_sequencer_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(2)) bus();

  sand_frame_sequencer #(
    .ACTIVE_COLUMNS(COLS),
    .ACTIVE_ROWS(ROWS),
    .ADDR_WIDTH(AW),
    .DATA_WIDTH(2),
    .FRAME_DIV(FDIV),
    .BRUSH_MAX(BMAX),
    .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk_i(clk),
    .reset_ni(reset_ni),
    .frame_tick_i(frame_tick),
    .engine_ready_o(engine_ready),
    .engine_done_i(engine_done),
    .clear_i(clear),
    .bus(bus),
    .buf_sel_o(buf_sel),
    .busy_o(busy),
    .overrun_o(overrun),
    .timeout_o(timeout)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  int exp_div = 0;
  bit exp_sel = 0;
  bit exp_over = 0;
  bit exp_to = 0;

  logic [AW-1:0] fa[$];
  logic [1:0]    fd[$];

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle_outputs(input string tag);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_eng"}, engine_ready, 0);
    chk({tag, "_rdy"}, bus.brush_ready_o, 0);
    chk({tag, "_wen"}, bus.wr_en_o, 0);
    chk({tag, "_both"}, bus.wr_both_o, 0);
    chk({tag, "_sel"}, buf_sel, exp_sel);
    chk({tag, "_ovr"}, overrun, exp_over);
    chk({tag, "_tmo"}, timeout, exp_to);
  endtask

  // one full frame: ticks until start, RUN, BRUSH over fa/fd, SWAP
  task automatic run_frame(input int done_after, input int over_at);
    int len, acc, nk;
    bit start;
    for (int t = 0; t < FDIV; t++) begin
      frame_tick = 1'b1;
      #1;
      start = (exp_div == FDIV - 1);
      chk("tick_eng", engine_ready, start);
      cyc();
      frame_tick = 1'b0;
      if (start) begin
        exp_div = 0;
        break;
      end
      exp_div++;
      #1 chk("gap_busy", busy, 0);
      cyc();
    end
    len = (done_after != 0) ? done_after : TMO;
    for (int r = 1; r <= len; r++) begin
      engine_done = (r == done_after);
      frame_tick = (r == over_at);
      #1;
      chk("run_rdy", bus.brush_ready_o, 0);
      chk("run_busy", busy, 1);
      chk("run_eng", engine_ready, 0);
      cyc();
    end
    engine_done = 1'b0;
    frame_tick = 1'b0;
    if (over_at > 0 && over_at <= len) exp_over = 1;
    if (done_after == 0) exp_to = 1;
    acc = 0;
    nk = fa.size();
    for (int k = 0; k <= fa.size(); k++) begin
      if (k < fa.size()) begin
        bus.brush_valid_i = 1'b1;
        bus.brush_addr_i = fa[k];
        bus.brush_data_i = fd[k];
        #1;
        chk("br_rdy", bus.brush_ready_o, 1);
        chk("br_wen", bus.wr_en_o, int'(fa[k]) < CELLS);
        chk("br_both", bus.wr_both_o, 0);
        if (int'(fa[k]) < CELLS) begin
          chk("br_addr", bus.wr_address_o, fa[k]);
          chk("br_data", bus.wr_data_o, fd[k]);
        end
        cyc();
        acc++;
        if (acc == BMAX) begin
          nk = k + 1;
          break;
        end
      end else begin
        bus.brush_valid_i = 1'b0;
        #1;
        chk("br_end_rdy", bus.brush_ready_o, 1);
        chk("br_end_wen", bus.wr_en_o, 0);
        cyc();
      end
    end
    bus.brush_valid_i = (nk < fa.size());
    if (nk < fa.size()) bus.brush_addr_i = fa[nk];
    #1;
    chk("swap_rdy", bus.brush_ready_o, 0);
    chk("swap_wen", bus.wr_en_o, 0);
    chk("swap_busy", busy, 1);
    chk("swap_sel", buf_sel, exp_sel);
    cyc();
    bus.brush_valid_i = 1'b0;
    exp_sel = !exp_sel;
    #1 idle_outputs("post");
  endtask

  task automatic rand_items();
    int n;
    fa.delete();
    fd.delete();
    n = $urandom_range(0, 5);
    for (int i = 0; i < n; i++) begin
      fa.push_back(AW'($urandom_range(0, 47)));
      fd.push_back(2'($urandom_range(0, 3)));
    end
  endtask

  initial begin
    bus.brush_valid_i = 1'b0;
    bus.brush_addr_i = '0;
    bus.brush_data_i = '0;
    repeat (2) @(negedge clk);
    reset_ni = 1'b1;
    #1 idle_outputs("reset");
    cyc();

    fa.delete();
    fd.delete();
    run_frame(5, 0);

    fa = '{AW'(3), AW'(7), AW'(40), AW'(9)};
    fd = '{2'd1, 2'd2, 2'd3, 2'd1};
    run_frame(3, 0);

    clear = 1'b1;
    frame_tick = 1'b1;
    #1 chk("clr_eng", engine_ready, 0);
    cyc();
    clear = 1'b0;
    frame_tick = 1'b0;
    for (int i = 0; i < CELLS; i++) begin
      #1;
      chk("clr_wen", bus.wr_en_o, 1);
      chk("clr_both", bus.wr_both_o, 1);
      chk("clr_data", bus.wr_data_o, 0);
      chk("clr_addr", bus.wr_address_o, i);
      chk("clr_eng2", engine_ready, 0);
      cyc();
    end
    #1 idle_outputs("clr_done");

    for (int f = 0; f < 8; f++) begin
      rand_items();
      run_frame($urandom_range(1, TMO), 0);
    end

    fa.delete();
    fd.delete();
    run_frame(0, 4);
    rand_items();
    run_frame(TMO, 0);

    clear = 1'b1;
    #1;
    cyc();
    clear = 1'b0;
    frame_tick = 1'b1;
    #1 chk("pend_eng", engine_ready, 0);
    cyc();
    frame_tick = 1'b0;
    for (int i = 0; i <= 12; i++) begin
      #1 chk("pend_addr", bus.wr_address_o, i);
      if (i < 12) cyc();
    end
    reset_ni = 1'b0;
    exp_sel = 0;
    exp_over = 0;
    exp_to = 0;
    exp_div = 0;
    #1 idle_outputs("async_rst");
    chk("async_addr", bus.wr_address_o, 0);
    @(negedge clk);
    reset_ni = 1'b1;
    #1 idle_outputs("after_rst");
    cyc();

    rand_items();
    run_frame($urandom_range(1, TMO), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sand_frame_sequencer.md
Name: sand_frame_sequencer

Overview:
Per-frame controller for the falling-sand cell-update engine. It starts the next-state engine on VGA frame ticks and waits for its done pulse. It then opens a bounded window for user brush writes into the freshly computed buffer and swaps the ping-pong buffer select. It also owns the global clear sweep, and sits between the VGA timing, the brush/input logic and the cell-update engine.

Parameters:
ACTIVE_COLUMNS, 640, grid width in cells
ACTIVE_ROWS, 480, grid height in cells
ADDR_WIDTH, $clog2(ACTIVE_COLUMNS*ACTIVE_ROWS), cell address width
DATA_WIDTH, 2, cell state width
FRAME_DIV, 1, run engine once every FRAME_DIV frame ticks (>=1)
BRUSH_MAX, 64, max brush writes accepted per frame window (>=1)
TIMEOUT_CYCLES, 1048576, max RUN cycles before forced abort

Ports:
clk_i  in  1  system clock
reset_ni  in  1  asynchronous active-low reset
frame_tick_i  in  1  1-cycle pulse at start of vertical blank
engine_ready_o  out  1  1-cycle start pulse to update engine
engine_done_i  in  1  1-cycle completion pulse from update engine
brush_valid_i  in  1  brush write request
brush_ready_o  out  1  brush write accept
brush_addr_i  in  ADDR_WIDTH  brush cell address
brush_data_i  in  DATA_WIDTH  brush cell state
clear_i  in  1  request full-grid clear (pulse or level)
wr_address_o  out  ADDR_WIDTH  write address to target buffer
wr_data_o  out  DATA_WIDTH  write data
wr_en_o  out  1  write strobe
wr_both_o  out  1  route write to both buffers (clear sweep)
buf_sel_o  out  1  displayed buffer select; engine writes the other
busy_o  out  1  state != IDLE
overrun_o  out  1  sticky: frame tick arrived while busy
timeout_o  out  1  sticky: engine failed to finish in TIMEOUT_CYCLES

Behaviour:
- Reset (reset_ni low, async): state IDLE; all outputs 0; buf_sel_o=0; div, brush, sweep and timeout counters 0; clear_pending=0; sticky flags cleared. Reset mid-operation aborts immediately. The engine shares this reset.
- clear_pending is set by clear_i in any state. It is cleared on the cycle CLEAR is entered.
- States: IDLE, RUN, BRUSH, SWAP, CLEAR.
- IDLE: on frame_tick_i:
  - If clear_pending or clear_i this cycle, go to CLEAR. Clear wins over run; div counter unchanged.
  - Else if div==FRAME_DIV-1: div<=0, engine_ready_o=1 this cycle (Mealy, same cycle as tick), go to RUN.
  - Else div<=div+1, stay IDLE.
- RUN: timeout counter increments each cycle.
  - engine_done_i: go to BRUSH; counter to 0.
  - Counter reaching TIMEOUT_CYCLES-1 without done: set timeout_o, go to BRUSH.
  - A done pulse arriving in the same cycle as the limit counts as done; no timeout.
- BRUSH: brush_ready_o=1.
  - Each cycle with brush_valid_i&brush_ready_o: write to buffer !buf_sel_o with wr_en_o=1, wr_address_o=brush_addr_i, wr_data_o=brush_data_i, same cycle (zero latency). Brush count increments.
  - brush_addr_i >= ACTIVE_COLUMNS*ACTIVE_ROWS is accepted but dropped (wr_en_o=0); it still counts.
  - Exit to SWAP when brush_valid_i is low, or on the cycle the BRUSH_MAX-th write is accepted. brush_ready_o is low from then on.
  - Entering BRUSH with brush_valid_i low takes exactly 1 cycle.
- SWAP: buf_sel_o toggles at the end of this cycle; brush count to 0; go to IDLE. Minimum tick-to-IDLE is RUN+BRUSH+SWAP.
- CLEAR: sweep counter 0..ACTIVE_COLUMNS*ACTIVE_ROWS-1, one address per cycle.
  - Each cycle: wr_en_o=1, wr_both_o=1, wr_data_o=0, wr_address_o=sweep.
  - After the last address: sweep to 0, go to IDLE. buf_sel_o is unchanged.
  - A clear_i arriving during CLEAR re-sets clear_pending, so another sweep runs at the next tick.
- frame_tick_i in any state other than IDLE sets overrun_o and the tick is dropped.
- brush_ready_o is 0 outside BRUSH. wr_both_o is 0 outside CLEAR. engine_ready_o is never asserted outside IDLE.
- All address arithmetic is ADDR_WIDTH unsigned. Comparisons use a constant cell count computed at elaboration width.

Optional Feature:
SAND_FRAME_STATS_EN:
- Defined: adds outputs frames_run_o[15:0] and last_run_cycles_o[31:0].
  - frames_run_o increments, wrapping, on each engine_ready_o.
  - last_run_cycles_o latches the RUN cycle count on exit from RUN, whether by done or timeout.
  - Both reset to 0.
- Undefined: these ports and registers are absent; all other behaviour is identical.

Test Plan:
- All tests use COLUMNS=8, ROWS=4, FRAME_DIV=2, BRUSH_MAX=3, TIMEOUT_CYCLES=16.
- Two ticks, done 5 cycles after start, brush_valid low -> engine_ready_o only on the 2nd tick; RUN 5 cycles, BRUSH 1 cycle, buf_sel_o 0->1.
- Brush valid held with addrs 3,7,40,9 -> writes at 3 and 7 only (40 dropped); exit after 3rd accept; addr 9 not accepted; buf_sel_o toggles.
- clear_i and tick same cycle in IDLE -> 32 cycles of wr_en_o=1, wr_both_o=1, data 0, addr 0..31; no engine_ready_o; buf_sel_o unchanged.
- No done after start -> timeout_o=1 after 16 RUN cycles; BRUSH/SWAP follow; extra tick during RUN -> overrun_o=1.
- reset_ni low mid-CLEAR at addr 12 -> all outputs 0 asynchronously; after release, IDLE with buf_sel_o=0, flags clear.
